// File: rtl/svpwm_duty_capture_pkg.sv
// Shared FOC constants and types for the SVPWM duty-capture decoder.
// Counter widths, gains, capture FSM encoding and snapshot bundle.
package svpwm_duty_capture_pkg;

  localparam int CNT_W      = 13;
  localparam int CNT_MAX    = 8191;
  localparam int KA         = 21845;
  localparam int KB         = 37837;
  localparam int PWM_PERIOD = 4999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] hu;
    logic [CNT_W-1:0] hv;
    logic [CNT_W-1:0] hw;
    logic [CNT_W-1:0] p;
  } snap_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] x,
    input logic             en
  );
    if (en && (x != CNT_W'(CNT_MAX)))
      return x + CNT_W'(1);
    return x;
  endfunction

endpackage

// File: rtl/svpwm_duty_to_ab.sv
// Converts a high-time snapshot to rounded alpha/beta voltages.
// C1 works on the shadow registers; C2 and C3 are registered.
module svpwm_duty_to_ab
  import svpwm_duty_capture_pkg::*;
(
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                snap_vld,
  input  snap_t               snap,
  output logic signed [15:0]  valpha,
  output logic signed [15:0]  vbeta,
  output logic [CNT_W-1:0]    period,
  output logic                valid
);

  logic signed [15:0] a_c;
  logic signed [13:0] b_c;
  logic signed [31:0] pa;
  logic signed [31:0] pb;
  logic [CNT_W-1:0]   c2_p;
  logic               c2_vld;

  assign a_c = {2'b00, snap.hu, 1'b0}
             - {3'b000, snap.hv}
             - {3'b000, snap.hw};
  assign b_c = {1'b0, snap.hv} - {1'b0, snap.hw};

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pa     <= '0;
      pb     <= '0;
      c2_p   <= '0;
      c2_vld <= 1'b0;
    end else begin
      c2_vld <= snap_vld;
      if (snap_vld) begin
        pa   <= 32'(a_c) * KA + 32'sd32768;
        pb   <= 32'(b_c) * KB + 32'sd32768;
        c2_p <= snap.p;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      valpha <= '0;
      vbeta  <= '0;
      period <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= c2_vld;
      if (c2_vld) begin
        valpha <= 16'(pa >>> 16);
        vbeta  <= 16'(pb >>> 16);
        period <= c2_p;
      end
    end
  end

endmodule

// File: rtl/svpwm_duty_capture.sv
// Measures per-phase PWM high time per sync window and hands
// each closed window to the alpha/beta reconstruction pipeline.
module svpwm_duty_capture
  import svpwm_duty_capture_pkg::*;
(
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iCapture_en,
  input  logic               iSync,
  input  logic               iPWM_u,
  input  logic               iPWM_v,
  input  logic               iPWM_w,
  output logic signed [15:0] oValpha,
  output logic signed [15:0] oVbeta,
  output logic [CNT_W-1:0]   oPeriod,
  output logic               oValid,
  output logic               oTimeout
);

  cap_state_e       state, state_n;
  logic             sync_prev;
  logic             sync_edge;
  logic [CNT_W-1:0] hu_c, hv_c, hw_c, p_c;
  logic             at_max;
  logic             snap_go, reload, clear, tmo;
  snap_t            shadow;
  logic             shadow_vld;

  assign sync_edge = iSync & ~sync_prev;
  assign at_max    = (p_c == CNT_W'(CNT_MAX));

  always_comb begin
    state_n = state;
    snap_go = 1'b0;
    reload  = 1'b0;
    clear   = 1'b0;
    tmo     = 1'b0;
    if (!iCapture_en) begin
      state_n = IDLE;
      clear   = 1'b1;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          state_n = ARM;
          clear   = 1'b1;
        end
        (state == ARM): begin
          if (sync_edge) begin
            state_n = MEASURE;
            reload  = 1'b1;
          end else begin
            clear = 1'b1;
          end
        end
        (state == MEASURE): begin
          // an edge coinciding with saturation wins over timeout
          if (sync_edge) begin
            snap_go = 1'b1;
            reload  = 1'b1;
          end else if (at_max) begin
            tmo     = 1'b1;
            state_n = ARM;
            clear   = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          clear   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      sync_prev <= 1'b0;
      oTimeout  <= 1'b0;
    end else begin
      state     <= state_n;
      sync_prev <= iSync;
      oTimeout  <= tmo;
    end
  end

  // reload with the edge-cycle sample so no PWM cycle is lost
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hu_c <= '0;
      hv_c <= '0;
      hw_c <= '0;
      p_c  <= '0;
    end else if (clear) begin
      hu_c <= '0;
      hv_c <= '0;
      hw_c <= '0;
      p_c  <= '0;
    end else if (reload) begin
      hu_c <= CNT_W'(iPWM_u);
      hv_c <= CNT_W'(iPWM_v);
      hw_c <= CNT_W'(iPWM_w);
      p_c  <= CNT_W'(1);
    end else begin
      hu_c <= sat_inc(hu_c, iPWM_u);
      hv_c <= sat_inc(hv_c, iPWM_v);
      hw_c <= sat_inc(hw_c, iPWM_w);
      p_c  <= sat_inc(p_c, 1'b1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      shadow     <= '0;
      shadow_vld <= 1'b0;
    end else begin
      shadow_vld <= snap_go;
      if (snap_go)
        shadow <= '{hu: hu_c, hv: hv_c, hw: hw_c, p: p_c};
    end
  end

  svpwm_duty_to_ab u_to_ab (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .snap_vld (shadow_vld),
    .snap     (shadow),
    .valpha   (oValpha),
    .vbeta    (oVbeta),
    .period   (oPeriod),
    .valid    (oValid)
  );

endmodule

// File: tb/tb_svpwm_duty_capture.sv
// Self-checking bench for svpwm_duty_capture.
// Windows of known duty are driven and decoded results compared.
module tb_svpwm_duty_capture;

  logic               iClk = 1'b0;
  logic               iRst_n;
  logic               iCapture_en;
  logic               iSync;
  logic               iPWM_u, iPWM_v, iPWM_w;
  logic signed [15:0] oValpha, oVbeta;
  logic [12:0]        oPeriod;
  logic               oValid, oTimeout;

  int n_cmp = 0;
  int n_err = 0;

  bit have_prev = 0;
  int ph, pv, pw, pp;
  int last_a = 0, last_b = 0, last_p = 0;

  svpwm_duty_capture dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iCapture_en (iCapture_en),
    .iSync       (iSync),
    .iPWM_u      (iPWM_u),
    .iPWM_v      (iPWM_v),
    .iPWM_w      (iPWM_w),
    .oValpha     (oValpha),
    .oVbeta      (oVbeta),
    .oPeriod     (oPeriod),
    .oValid      (oValid),
    .oTimeout    (oTimeout)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic int fdiv(input int n, input int d);
    int q;
    q = n / d;
    if ((n % d != 0) && (n < 0))
      q = q - 1;
    return q;
  endfunction

  function automatic int ref_alpha(input int hu, hv, hw);
    return fdiv((2 * hu - hv - hw) * 21845 + 32768, 65536);
  endfunction

  function automatic int ref_beta(input int hv, hw);
    return fdiv((hv - hw) * 37837 + 32768, 65536);
  endfunction

  // Drive ncyc cycles of a window of length p starting with a sync edge.
  task automatic run_window(input int hu, hv, hw, p, ncyc);
    int lu, lv, lw, ea, eb;
    lu = (p - hu) / 2;
    lv = (p - hv) / 2;
    lw = (p - hw) / 2;
    ea = ref_alpha(ph, pv, pw);
    eb = ref_beta(pv, pw);
    for (int i = 0; i < ncyc; i++) begin
      iSync  = (i == 0);
      iPWM_u = (i >= lu) && (i < lu + hu);
      iPWM_v = (i >= lv) && (i < lv + hv);
      iPWM_w = (i >= lw) && (i < lw + hw);
      tick();
      n_cmp++;
      if (i + 1 == 3 && have_prev) begin
        if (oValid !== 1'b1 || int'(oValpha) !== ea ||
            int'(oVbeta) !== eb || int'(oPeriod) !== pp) begin
          n_err++;
          $display("FAIL window_result: got v=%0b a=%0d b=%0d p=%0d want v=1 a=%0d b=%0d p=%0d",
                   oValid, oValpha, oVbeta, oPeriod, ea, eb, pp);
        end
        last_a = ea;
        last_b = eb;
        last_p = pp;
      end else if (oValid !== 1'b0) begin
        n_err++;
        $display("FAIL spurious_valid: cycle %0d got %0b want 0", i + 1, oValid);
      end
      n_cmp++;
      if (oTimeout !== 1'b0) begin
        n_err++;
        $display("FAIL spurious_timeout: cycle %0d got %0b want 0", i + 1, oTimeout);
      end
    end
    iSync = 1'b0;
    if (ncyc == p) begin
      have_prev = 1;
      ph = hu; pv = hv; pw = hw; pp = p;
    end
  endtask

  task automatic check_held(input string nm);
    n_cmp++;
    if (oValid !== 1'b0 || int'(oValpha) !== last_a ||
        int'(oVbeta) !== last_b || int'(oPeriod) !== last_p) begin
      n_err++;
      $display("FAIL %s: got v=%0b a=%0d b=%0d p=%0d want v=0 a=%0d b=%0d p=%0d",
               nm, oValid, oValpha, oVbeta, oPeriod, last_a, last_b, last_p);
    end
  endtask

  task automatic random_window(input int pmin, pmax);
    int p;
    p = $urandom_range(pmax, pmin);
    run_window($urandom_range(p, 0), $urandom_range(p, 0),
               $urandom_range(p, 0), p, p);
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; iCapture_en = 1'b0; iSync = 1'b0;
    iPWM_u = 1'b0; iPWM_v = 1'b0; iPWM_w = 1'b0;
    tick(); tick();
    n_cmp++;
    if (oValpha !== 16'sd0 || oVbeta !== 16'sd0 || oPeriod !== 13'd0 ||
        oValid !== 1'b0 || oTimeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got a=%0d b=%0d p=%0d v=%0b t=%0b want all 0",
               oValpha, oVbeta, oPeriod, oValid, oTimeout);
    end
    iRst_n = 1'b1;
    tick();
    iCapture_en = 1'b1;
    repeat (4) tick();
    check_held("idle_after_reset");
  endtask

  task automatic test_fixed_vectors();
    have_prev = 0;
    run_window(2500, 2500, 2500, 5000, 5000);
    run_window(4000, 1000, 1000, 5000, 5000);
    run_window(2000, 3000, 1000, 5000, 5000);
    run_window(1000, 4000, 4000, 5000, 5000);
    run_window(0, 0, 0, 8, 8);
  endtask

  task automatic test_boundary();
    run_window(40, 0, 0, 40, 40);
    run_window(0, 33, 0, 33, 33);
    run_window(0, 0, 4, 4, 4);
    run_window(5, 5, 5, 5, 5);
  endtask

  task automatic test_random();
    repeat (25) random_window(4, 400);
  endtask

  task automatic test_timeout();
    int ea, eb;
    ea = ref_alpha(ph, pv, pw);
    eb = ref_beta(pv, pw);
    iPWM_u = 1'b0; iPWM_v = 1'b0; iPWM_w = 1'b0;
    for (int c = 0; c < 8200; c++) begin
      iSync = (c == 0);
      tick();
      if (c + 1 == 3) begin
        n_cmp++;
        if (oValid !== 1'b1 || int'(oValpha) !== ea ||
            int'(oVbeta) !== eb || int'(oPeriod) !== pp) begin
          n_err++;
          $display("FAIL pre_timeout_result: got v=%0b a=%0d b=%0d want v=1 a=%0d b=%0d",
                   oValid, oValpha, oVbeta, ea, eb);
        end
        last_a = ea; last_b = eb; last_p = pp;
      end else if (oValid !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL timeout_valid: cycle %0d got 1 want 0", c + 1);
      end
      if (c + 1 == 8192 || oTimeout !== 1'b0) begin
        n_cmp++;
        if (oTimeout !== (c + 1 == 8192)) begin
          n_err++;
          $display("FAIL timeout_pulse: cycle %0d got %0b want %0b",
                   c + 1, oTimeout, (c + 1 == 8192));
        end
      end
    end
    iSync = 1'b0;
    have_prev = 0;
    random_window(10, 200);
    random_window(10, 200);
    run_window(0, 0, 0, 6, 6);
  endtask

  task automatic test_abort();
    random_window(60, 200);
    run_window(30, 30, 30, 100, 50);
    iCapture_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_held("abort_hold");
    end
    iCapture_en = 1'b1;
    repeat (5) tick();
    check_held("abort_rearm");
    have_prev = 0;
    random_window(10, 200);
    random_window(10, 200);
    run_window(0, 0, 0, 6, 6);
  endtask

  task automatic test_reset_mid();
    random_window(20, 100);
    run_window(3, 3, 3, 10, 1);
    iRst_n = 1'b0;
    #1;
    last_a = 0; last_b = 0; last_p = 0;
    check_held("reset_mid_clear");
    for (int i = 0; i < 4; i++) begin
      tick();
      check_held("reset_mid_drop");
    end
    iRst_n = 1'b1;
    repeat (4) tick();
    check_held("reset_mid_rearm");
    have_prev = 0;
    random_window(10, 200);
    random_window(10, 200);
    run_window(0, 0, 0, 6, 6);
  endtask

  initial begin
    test_reset();
    test_fixed_vectors();
    test_boundary();
    test_random();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
